// File: rtl/dcache_pkg.sv
// Shared field widths, FSM encoding and set metadata for the direct-mapped data cache.
// Address split: tag [31:9], index [8:5], word select [4:2], byte offset [1:0].
package dcache_pkg;

  localparam int TAG_W     = 23;
  localparam int IDX_W     = 4;
  localparam int OFF_W     = 5;
  localparam int WSEL_W    = 3;
  localparam int WORD_W    = 32;
  localparam int LINE_BITS = 256;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } meta_t;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: async read of the indexed set, sync line fill or word write.
// Only valid/dirty are reset; a line fill takes priority over a word write.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_SETS  = 2 ** IDX_W,
  parameter int LINE_BITS = dcache_pkg::LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx,
  output meta_t                rd_meta,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 line_we,
  input  logic [TAG_W-1:0]     line_tag,
  input  logic [LINE_BITS-1:0] line_dat,
  input  logic                 word_we,
  input  logic [WSEL_W-1:0]    word_sel,
  input  logic [WORD_W-1:0]    word_dat
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[idx]  <= line_tag;
      data_q[idx] <= line_dat;
    end else if (word_we) begin
      data_q[idx][word_sel*WORD_W +: WORD_W] <= word_dat;
    end
  end

  assign rd_meta.valid = valid_q[idx];
  assign rd_meta.dirty = dirty_q[idx];
  assign rd_meta.tag   = tag_q[idx];
  assign rd_line       = data_q[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: hits serve in the same cycle with no stall.
// A miss stalls the CPU for one memory latency (clean victim) or two (dirty victim) plus 2 cycles.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_SETS  = 2 ** IDX_W,
  parameter int LINE_BITS = dcache_pkg::LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_t               state_q, state_d;
  meta_t                rd_meta;
  logic [LINE_BITS-1:0] rd_line;
  logic                 line_we, word_we, hit;
  logic [TAG_W-1:0]     cpu_tag;
  logic [IDX_W-1:0]     cpu_idx;
  logic [WSEL_W-1:0]    cpu_wsel;
  logic [WORD_W-1:0]    hit_word;
  logic                 addr_unused;

  assign cpu_tag     = cpu_addr_i[OFF_W+IDX_W +: TAG_W];
  assign cpu_idx     = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_wsel    = cpu_addr_i[2 +: WSEL_W];
  assign addr_unused = ^cpu_addr_i[1:0];

  assign hit      = cpu_req_i && rd_meta.valid && (rd_meta.tag == cpu_tag);
  assign hit_word = rd_line[cpu_wsel*WORD_W +: WORD_W];

  dcache_sram #(
    .NUM_SETS  (NUM_SETS),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx      (cpu_idx),
    .rd_meta  (rd_meta),
    .rd_line  (rd_line),
    .line_we  (line_we),
    .line_tag (cpu_tag),
    .line_dat (mem_data_i),
    .word_we  (word_we),
    .word_sel (cpu_wsel),
    .word_dat (cpu_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // CPU inputs are held stable while stalled, so the index/tag always name the pending access.
  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (cpu_we_i) word_we    = 1'b1;
          else          cpu_data_o = hit_word;
        end else if (cpu_req_i) begin
          cpu_stall_o = 1'b1;
          state_d     = (rd_meta.valid && rd_meta.dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(rd_meta.tag, cpu_idx);
        mem_data_o   = rd_line;
        if (mem_ack_i) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = line_addr(cpu_tag, cpu_idx);
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        cpu_stall_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset overrides everything: quiet outputs and no array writes.
    if (!rst_i) begin
      state_d      = ST_IDLE;
      cpu_stall_o  = 1'b0;
      cpu_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      line_we      = 1'b0;
      word_we      = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: negedge memory responder with programmable latency and a
// reference model built on a flat golden word memory plus per-set residency.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int           stall;
    logic [31:0]  rdata;
    int           nwb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    int           nrd;
    logic [31:0]  rd_addr;
    logic         wr;
  } res_t;

  // Backing memory (what Data_Memory holds) and golden memory (what the CPU must observe).
  logic [255:0] bmem [logic [31:0]];
  logic [31:0]  gmem [logic [31:0]];
  bit           res_valid [16];
  bit           res_dirty [16];
  logic [31:0]  res_line  [16];

  int           mem_lat  = 10;
  bit           mem_auto = 1'b1;
  int           cnt = 0;
  int           obs_nwb, obs_nrd;
  logic [31:0]  obs_wb_addr, obs_rd_addr;
  logic [255:0] obs_wb_line;
  logic         obs_wr;

  function automatic logic [255:0] backing_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w*4)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [31:0] golden_word(input logic [31:0] a);
    logic [255:0] l;
    if (gmem.exists(a)) return gmem[a];
    l = backing_line({a[31:5], 5'b0});
    return l[a[4:2]*32 +: 32];
  endfunction

  function automatic string res_str(input res_t o, input res_t e);
    return $sformatf("stall=%0d exp %0d rdata=%h exp %h nwb=%0d exp %0d wb_addr=%h exp %h wb_line_eq=%0b nrd=%0d exp %0d rd_addr=%h exp %h wr=%0b exp %0b",
                     o.stall, e.stall, o.rdata, e.rdata, o.nwb, e.nwb, o.wb_addr, e.wb_addr,
                     o.wb_line === e.wb_line, o.nrd, e.nrd, o.rd_addr, e.rd_addr, o.wr, e.wr);
  endfunction

  // Memory responder: acks on the mem_lat-th cycle of a request, one pulse per request.
  initial forever begin
    @(negedge clk);
    if (mem_auto) begin
      if (!rst_i || !mem_enable_o) begin
        cnt = 0;
        mem_ack_i = 1'b0;
      end else begin
        if (mem_write_o) obs_wr = 1'b1;
        cnt = mem_ack_i ? 1 : cnt + 1;
        mem_ack_i = 1'b0;
        if (cnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) begin
            bmem[mem_addr_o] = mem_data_o;
            obs_nwb++;
            obs_wb_addr = mem_addr_o;
            obs_wb_line = mem_data_o;
          end else begin
            mem_data_i = backing_line(mem_addr_o);
            obs_nrd++;
            obs_rd_addr = mem_addr_o;
          end
        end
      end
    end
  end

  task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                              output res_t e);
    logic [31:0] la;
    int idx;
    la  = {a[31:5], 5'b0};
    idx = int'(a[8:5]);
    e   = '0;
    if (!(res_valid[idx] && res_line[idx] == la)) begin
      if (res_valid[idx] && res_dirty[idx]) begin
        e.nwb     = 1;
        e.wr      = 1'b1;
        e.wb_addr = res_line[idx];
        for (int w = 0; w < 8; w++) e.wb_line[w*32 +: 32] = golden_word(res_line[idx] + 32'(w*4));
        e.stall += mem_lat;
      end
      e.nrd     = 1;
      e.rd_addr = la;
      e.stall  += mem_lat + 2;
      res_valid[idx] = 1'b1;
      res_dirty[idx] = 1'b0;
      res_line[idx]  = la;
    end
    if (we) begin
      gmem[a] = d;
      res_dirty[idx] = 1'b1;
    end else begin
      e.rdata = golden_word(a);
    end
  endtask

  // Reset drops dirty lines: the CPU view of those lines falls back to backing memory.
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      if (res_valid[i] && res_dirty[i])
        for (int w = 0; w < 8; w++) gmem.delete(res_line[i] + 32'(w*4));
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                           output res_t o);
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
    obs_nwb = 0; obs_nrd = 0; obs_wb_addr = '0; obs_rd_addr = '0; obs_wb_line = '0; obs_wr = 1'b0;
    #1;
    o = '0;
    while (cpu_stall_o !== 1'b0 && o.stall < 500) begin
      o.stall++;
      @(negedge clk);
      #1;
    end
    o.rdata = cpu_data_o; o.nwb = obs_nwb; o.wb_addr = obs_wb_addr; o.wb_line = obs_wb_line;
    o.nrd = obs_nrd; o.rd_addr = obs_rd_addr; o.wr = obs_wr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = $urandom & 32'hFFFF_FFFC;
    cpu_data_i = $urandom; mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cpu_stall_o, cpu_data_o, mem_enable_o, mem_write_o, mem_addr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs stall=%b data=%h en=%b wr=%b addr=%h required all 0",
               cpu_stall_o, cpu_data_o, mem_enable_o, mem_write_o, mem_addr_o);
    end
    checks++;
    if (mem_data_o !== '0) begin
      failures++;
      $display("FAIL reset_mem_data got %h required 0", mem_data_o);
    end
    @(negedge clk);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_stall_o, mem_enable_o} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle stall=%b en=%b required 0 0", cpu_stall_o, mem_enable_o);
    end
  endtask

  task automatic test_no_req();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_req_i = 1'b0; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom & 32'h0000_0FFC;
      #1;
      checks++;
      if ({cpu_stall_o, cpu_data_o, mem_enable_o} !== '0) begin
        failures++;
        $display("FAIL no_req stall=%b data=%h en=%b required 0", cpu_stall_o, cpu_data_o, mem_enable_o);
      end
    end
  endtask

  task automatic test_cold_load();
    res_t o, e;
    logic [255:0] l;
    l = backing_line(32'h40);
    l[31:0] = 32'h1111_1111;
    bmem[32'h40] = l;
    mem_lat = 10;
    model_access(1'b0, 32'h40, '0, e);
    do_access(1'b0, 32'h40, '0, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL cold_load_model %s", res_str(o, e)); end
    checks++;
    if (o.stall != 12 || o.rdata !== 32'h1111_1111 || o.nrd != 1 || o.nwb != 0) begin
      failures++;
      $display("FAIL cold_load_spec stall=%0d rdata=%h nrd=%0d nwb=%0d required 12 11111111 1 0",
               o.stall, o.rdata, o.nrd, o.nwb);
    end
  endtask

  task automatic test_store_hit();
    res_t o, e;
    model_access(1'b1, 32'h44, 32'hDEAD_BEEF, e);
    do_access(1'b1, 32'h44, 32'hDEAD_BEEF, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL store_hit_model %s", res_str(o, e)); end
    model_access(1'b0, 32'h44, '0, e);
    do_access(1'b0, 32'h44, '0, o);
    checks++;
    if (o.stall != 0 || o.rdata !== 32'hDEAD_BEEF || o.nrd != 0) begin
      failures++;
      $display("FAIL store_then_load stall=%0d rdata=%h nrd=%0d required 0 deadbeef 0",
               o.stall, o.rdata, o.nrd);
    end
  endtask

  task automatic test_dirty_evict();
    res_t o, e;
    model_access(1'b0, 32'h240, '0, e);
    do_access(1'b0, 32'h240, '0, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL dirty_evict_model %s", res_str(o, e)); end
    checks++;
    if (o.nwb != 1 || o.wb_addr !== 32'h40 || o.wb_line[63:32] !== 32'hDEAD_BEEF ||
        o.rd_addr !== 32'h240 || o.stall != 22) begin
      failures++;
      $display("FAIL dirty_evict_spec nwb=%0d wb_addr=%h word1=%h rd_addr=%h stall=%0d required 1 40 deadbeef 240 22",
               o.nwb, o.wb_addr, o.wb_line[63:32], o.rd_addr, o.stall);
    end
  endtask

  task automatic test_clean_evict();
    res_t o, e;
    model_access(1'b0, 32'h448, '0, e);
    do_access(1'b0, 32'h448, '0, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL clean_evict_model %s", res_str(o, e)); end
    checks++;
    if (o.wr !== 1'b0 || o.nwb != 0 || o.stall != 12) begin
      failures++;
      $display("FAIL clean_evict_spec wr_seen=%b nwb=%0d stall=%0d required 0 0 12", o.wr, o.nwb, o.stall);
    end
  endtask

  task automatic test_reset_mid_alloc();
    res_t o, e;
    int k;
    mem_auto = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h840;
    k = 0;
    #1;
    while (mem_enable_o !== 1'b1 && k < 10) begin k++; @(negedge clk); #1; end
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h840) begin
      failures++;
      $display("FAIL alloc_request en=%b wr=%b addr=%h required 1 0 00000840", mem_enable_o, mem_write_o, mem_addr_o);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if ({cpu_stall_o, cpu_data_o, mem_enable_o, mem_write_o, mem_addr_o} !== '0 || mem_data_o !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs stall=%b en=%b wr=%b addr=%h required all 0",
               cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o);
    end
    @(negedge clk);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    mem_ack_i = 1'b1; mem_data_i = {8{$urandom}};
    @(negedge clk);
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({cpu_stall_o, mem_enable_o, cpu_data_o} !== '0) begin
        failures++;
        $display("FAIL late_ack_ignored stall=%b en=%b data=%h required 0", cpu_stall_o, mem_enable_o, cpu_data_o);
      end
      @(negedge clk);
    end
    cnt = 0; mem_auto = 1'b1;
    model_access(1'b0, 32'h840, '0, e);
    do_access(1'b0, 32'h840, '0, o);
    checks++;
    if (o !== e || o.stall != mem_lat + 2) begin
      failures++;
      $display("FAIL reload_after_reset %s", res_str(o, e));
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    mem_lat = 3;
    model_access(1'b0, 32'h1000, '0, e);
    do_access(1'b0, 32'h1000, '0, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL b2b_fill %s", res_str(o, e)); end
    for (int w = 0; w < 8; w++) begin
      model_access(1'b0, 32'h1000 + 32'(w*4), '0, e);
      do_access(1'b0, 32'h1000 + 32'(w*4), '0, o);
      checks++;
      if (o !== e || o.stall != 0) begin failures++; $display("FAIL b2b_hit w=%0d %s", w, res_str(o, e)); end
    end
    model_access(1'b1, 32'h100C, 32'hCAFE_0003, e);
    do_access(1'b1, 32'h100C, 32'hCAFE_0003, o);
    model_access(1'b0, 32'h100C, '0, e);
    do_access(1'b0, 32'h100C, '0, o);
    checks++;
    if (o !== e || o.rdata !== 32'hCAFE_0003) begin failures++; $display("FAIL b2b_store_load %s", res_str(o, e)); end
  endtask

  task automatic test_random();
    res_t o, e;
    logic [31:0] a, d;
    bit we;
    for (int i = 0; i < 80; i++) begin
      mem_lat = $urandom_range(1, 5);
      a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
      we = 1'($urandom);
      d  = $urandom;
      model_access(we, a, d, e);
      do_access(we, a, d, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL random i=%0d we=%0b addr=%h %s", i, we, a, res_str(o, e)); end
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout simulation time exceeded");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_no_req();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_clean_evict();
    test_reset_mid_alloc();
    test_back_to_back();
    test_random();
    @(negedge clk);
    cpu_req_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
